wb_vmemem_master: RTL and testbench

//  Upstream bridge for the generated register blocks that use the VME memory-strobe interface.

---
 rtl/wb_vmemem_master.sv | 104 ++++++++++
 tb/tb_wb_vmemem_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_vmemem_master.sv
// Wishbone single-access bridge onto a VME memory-strobe register interface.
// Issues one-cycle rd/wr strobes, waits for the matching done, and errors out via a watchdog.
module wb_vmemem_master #(
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [15:0]       wb_dat_i,
  output logic [15:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wrdata_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  input  logic [15:0]       mem_rddata_i,
  input  logic              mem_rddone_i,
  input  logic              mem_wrdone_i,
  output logic [7:0]        timeout_cnt_o
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] watchdog;
  logic        abort_q;
  logic        done;
  logic        expired;
  logic        aborting;

  always_comb begin
    done     = ((state == RD_WAIT) && mem_rddone_i) ||
               ((state == WR_WAIT) && mem_wrdone_i);
    expired  = (watchdog == WD_LAST);
    // A cycle drop on the finishing edge still counts as an abort.
    aborting = abort_q || !wb_cyc_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      watchdog      <= '0;
      abort_q       <= 1'b0;
      wb_dat_o      <= '0;
      wb_ack_o      <= 1'b0;
      wb_err_o      <= 1'b0;
      wb_stall_o    <= 1'b0;
      mem_addr_o    <= '0;
      mem_wrdata_o  <= '0;
      mem_rd_o      <= 1'b0;
      mem_wr_o      <= 1'b0;
      timeout_cnt_o <= '0;
    end else begin
      mem_rd_o <= 1'b0;
      mem_wr_o <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state)
        IDLE: begin
          wb_stall_o <= 1'b0;
          if (wb_cyc_i && wb_stb_i && !wb_stall_o) begin
            mem_addr_o   <= wb_adr_i;
            mem_wrdata_o <= wb_dat_i;
            mem_rd_o     <= !wb_we_i;
            mem_wr_o     <= wb_we_i;
            state        <= wb_we_i ? WR_WAIT : RD_WAIT;
            watchdog     <= '0;
            abort_q      <= 1'b0;
            wb_stall_o   <= 1'b1;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (!wb_cyc_i) abort_q <= 1'b1;
          if (done || expired) begin
            // Stall stays high through the ack/err cycle so no request overlaps it.
            state   <= IDLE;
            abort_q <= 1'b0;
            if (aborting) begin
              wb_stall_o <= 1'b0;
            end else if (done) begin
              wb_ack_o <= 1'b1;
              if (state == RD_WAIT) wb_dat_o <= mem_rddata_i;
            end else begin
              wb_err_o <= 1'b1;
              if (timeout_cnt_o != 8'hFF) timeout_cnt_o <= timeout_cnt_o + 8'd1;
            end
          end else begin
            watchdog <= watchdog + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_vmemem_master.sv
// Bench for wb_vmemem_master: directed bus sequences with a response scoreboard.
module tb_wb_vmemem_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [1:0]  wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_stall_o;
  logic [1:0]  mem_addr_o;
  logic [15:0] mem_wrdata_o;
  logic        mem_rd_o, mem_wr_o;
  logic [15:0] mem_rddata_i;
  logic        mem_rddone_i, mem_wrdone_i;
  logic [7:0]  timeout_cnt_o;

  typedef struct {
    logic        err;
    logic        is_rd;
    logic [15:0] dat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  wb_vmemem_master #(.ADDR_W(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_stall_o(wb_stall_o),
    .mem_addr_o(mem_addr_o), .mem_wrdata_o(mem_wrdata_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
    .mem_rddata_i(mem_rddata_i), .mem_rddone_i(mem_rddone_i),
    .mem_wrdone_i(mem_wrdone_i), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every ack/err must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (wb_ack_o === 1'b1 || wb_err_o === 1'b1)) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", {wb_ack_o, wb_err_o}, 0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_err", wb_err_o, mon_e.err);
        check("resp_ack", wb_ack_o, !mon_e.err);
        if (mon_e.is_rd && !mon_e.err) check("resp_dat", wb_dat_o, mon_e.dat);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accepting edge T with stb already dropped.
  task automatic issue(input logic we, input logic [1:0] adr, input logic [15:0] dat);
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    step();
    wb_stb_i = 1'b0;
  endtask

  task automatic push(input logic err, input logic is_rd, input logic [15:0] dat);
    exp_t e;
    e.err = err;
    e.is_rd = is_rd;
    e.dat = dat;
    sb.push_back(e);
  endtask

  task automatic wait_free;
    int unsigned n = 0;
    while (wb_stall_o !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    if (wb_stall_o !== 1'b0) check("bounded_wait", wb_stall_o, 0);
    wb_cyc_i = 1'b0;
  endtask

  task automatic run_timeout(input int unsigned n);
    issue(1'b0, 2'd3, 16'h0);
    push(1'b1, 1'b1, 16'h0);
    wait_free();
    check("tcnt_sat", timeout_cnt_o, (n > 255) ? 255 : n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_dat_i = 0;
    mem_rddata_i = 0; mem_rddone_i = 0; mem_wrdone_i = 0;
    repeat (3) step();
    check("rst_ack_err_stall", {wb_ack_o, wb_err_o, wb_stall_o}, 0);
    check("rst_strobes", {mem_rd_o, mem_wr_o}, 0);
    check("rst_data", {mem_addr_o, mem_wrdata_o, wb_dat_o, timeout_cnt_o}, 0);
    rst_n = 1'b1;
    step();

    // Read with a one-cycle slave; a stray write-done must not complete it.
    issue(1'b0, 2'd1, 16'h0);
    check("rd_strobe", {mem_rd_o, mem_wr_o}, 2'b10);
    check("rd_addr", mem_addr_o, 1);
    check("rd_stall", wb_stall_o, 1);
    push(1'b0, 1'b1, 16'hBEEF);
    mem_wrdone_i = 1'b1;
    step();
    mem_wrdone_i = 1'b0;
    check("rd_strobe_1cyc", mem_rd_o, 0);
    check("rd_no_early_ack", wb_ack_o, 0);
    mem_rddone_i = 1'b1; mem_rddata_i = 16'hBEEF;
    step();
    mem_rddone_i = 1'b0; mem_rddata_i = 16'h0;
    check("rd_ack_latency", wb_ack_o, 1);
    check("rd_data", wb_dat_o, 16'hBEEF);
    check("rd_stall_on_ack", wb_stall_o, 1);
    step();
    check("rd_ack_1cyc", wb_ack_o, 0);
    wait_free();

    // Write: outputs held while the bus inputs change; a stray read-done is ignored.
    issue(1'b1, 2'd0, 16'h1234);
    check("wr_strobe", {mem_rd_o, mem_wr_o}, 2'b01);
    check("wr_data", mem_wrdata_o, 16'h1234);
    push(1'b0, 1'b0, 16'h0);
    wb_dat_i = 16'hFFFF; wb_adr_i = 2'd3;
    mem_rddone_i = 1'b1; mem_rddata_i = 16'hDEAD;
    step();
    mem_rddone_i = 1'b0;
    check("wr_hold_data", mem_wrdata_o, 16'h1234);
    check("wr_hold_addr", mem_addr_o, 0);
    check("wr_no_strobe", {mem_rd_o, mem_wr_o}, 0);
    mem_wrdone_i = 1'b1;
    step();
    mem_wrdone_i = 1'b0;
    check("wr_ack_latency", wb_ack_o, 1);
    check("wr_hold_data_ack", mem_wrdata_o, 16'h1234);
    check("wr_keeps_rd_data", wb_dat_o, 16'hBEEF);
    wait_free();

    // Timeout with TIMEOUT=4: err after the fourth waiting cycle.
    issue(1'b0, 2'd2, 16'h0);
    push(1'b1, 1'b1, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_no_early_err", wb_err_o, 0);
    end
    step();
    check("to_err", wb_err_o, 1);
    check("to_cnt", timeout_cnt_o, 1);
    check("to_no_ack", wb_ack_o, 0);
    wait_free();
    check("to_idle", wb_stall_o, 0);

    // Done on the expiry cycle wins over the watchdog.
    issue(1'b0, 2'd1, 16'h0);
    push(1'b0, 1'b1, 16'hA5A5);
    step(); step(); step();
    mem_rddone_i = 1'b1; mem_rddata_i = 16'hA5A5;
    step();
    mem_rddone_i = 1'b0;
    check("race_ack", {wb_ack_o, wb_err_o}, 2'b10);
    step();
    check("race_cnt", timeout_cnt_o, 1);
    wait_free();

    // Abort with a late done: silent return, data untouched.
    issue(1'b0, 2'd1, 16'h0);
    wb_cyc_i = 1'b0;
    step();
    mem_rddone_i = 1'b1; mem_rddata_i = 16'h5555;
    step();
    mem_rddone_i = 1'b0;
    check("abort_no_resp", {wb_ack_o, wb_err_o}, 0);
    wait_free();
    check("abort_idle", wb_stall_o, 0);
    check("abort_keeps_data", wb_dat_o, 16'hA5A5);

    // Abort that runs into the watchdog: no err, no count.
    issue(1'b1, 2'd2, 16'h9999);
    wb_cyc_i = 1'b0;
    repeat (6) step();
    check("abort_to_cnt", timeout_cnt_o, 1);
    check("abort_to_idle", wb_stall_o, 0);

    // Following read must complete normally.
    issue(1'b0, 2'd2, 16'h0);
    push(1'b0, 1'b1, 16'h0F0F);
    step();
    mem_rddone_i = 1'b1; mem_rddata_i = 16'h0F0F;
    step();
    mem_rddone_i = 1'b0;
    wait_free();
    check("post_abort_data", wb_dat_o, 16'h0F0F);

    // Done pulses while idle are ignored.
    mem_rddone_i = 1'b1; mem_wrdone_i = 1'b1;
    step(); step();
    mem_rddone_i = 1'b0; mem_wrdone_i = 1'b0;
    step();
    check("idle_done_ignored", {wb_ack_o, wb_err_o, wb_stall_o}, 0);

    // Saturating timeout counter.
    for (int n = 2; n <= 300; n++) run_timeout(n);

    // Reset in WR_WAIT, then a late write-done.
    issue(1'b1, 2'd3, 16'h7777);
    step();
    rst_n = 1'b0;
    step();
    check("wrst_ctl", {wb_ack_o, wb_err_o, wb_stall_o, mem_rd_o, mem_wr_o}, 0);
    check("wrst_data", {mem_addr_o, mem_wrdata_o, wb_dat_o, timeout_cnt_o}, 0);
    rst_n = 1'b1;
    wb_cyc_i = 1'b0;
    mem_wrdone_i = 1'b1;
    step();
    mem_wrdone_i = 1'b0;
    repeat (3) step();
    check("wrst_late_done", {wb_ack_o, wb_err_o, wb_stall_o}, 0);

    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
